player_anim_sequencer: RTL and testbench
========================================

PLAYER_ANIM_SEQUENCER -- requirements
Module: player_anim_sequencer

Interface
REQ-001 Parameter WALK_FRAMES, default 2: number of walking frames, cycled in order; range 2..8.
REQ-002 Parameter ATTACK_FRAMES, default 2: number of attack frames per attack; range 1..8.
REQ-003 Parameter HIT_FRAME, default 1: attack frame index (0-based) on which the hit lands; must be less than ATTACK_FRAMES.
REQ-004 Parameter FRAME_CYCLES, default 16_650_000: clk cycles each attack frame is held.
REQ-005 Parameter WALK_CYCLES, default 15_000_000: clk cycles each walking frame is held.
REQ-006 Parameter HURT_CYCLES, default 25_000_000: clk cycles the hurt pose is held.
REQ-007 Parameter FID_W, default 4: width of frame_id; must satisfy 2^FID_W >= 3+WALK_FRAMES+ATTACK_FRAMES.
REQ-008 Port clk, input, 1: system clock, 100 MHz.
REQ-009 Port rst_l, input, 1: reset, synchronous, active-low.
REQ-010 Port action, input, 7: bits[5:0] are the action code, bit[6] is the facing direction.
REQ-011 Port attack_grant, input, 1: single-cycle attack request.
REQ-012 Port damage_in, input, 1: single-cycle pulse meaning this player was hit.
REQ-013 Port frame_id, output, FID_W: selected sprite frame, registered.
REQ-014 Port mirror, output, 1: horizontal flip for the sprite ROMs, registered.
REQ-015 Port busy, output, 1: high while in ATTACK or HURT.
REQ-016 Port hit_pulse, output, 1: one-cycle strobe on entry into attack frame HIT_FRAME.
REQ-017 Port enemy_damage_animation, output, 1: high for every cycle that attack frame HIT_FRAME is displayed.

Function
REQ-018 Frame encoding SHALL be:
- 0 = standing
- 1 = crouching
- 2..2+WALK_FRAMES-1 = walking
- ATK_BASE = 2+WALK_FRAMES, attack frames follow in order
- HURT_ID = ATK_BASE+ATTACK_FRAMES
REQ-019 Action decode SHALL be: action[5:0]=6'b000001 -> walking; 6'b000010 -> crouching; any other value, including 6'b100000, -> standing.
REQ-020 The FSM SHALL have exactly three states: IDLE (locomotion), ATTACK, HURT.
REQ-021 All outputs SHALL register on the same edge as the state update, so attack_grant sampled at edge N gives frame_id=ATK_BASE after edge N (1-cycle latency).
REQ-022 IDLE walking SHALL advance the walk index every WALK_CYCLES cycles, wrapping from WALK_FRAMES-1 to 0; the index and its counter SHALL clear to 0 whenever the decoded action is not walking.
REQ-023 IDLE + attack_grant SHALL enter ATTACK at frame 0 with the frame counter at 0, and SHALL latch action[6] as the attack facing.
REQ-024 In ATTACK, each frame SHALL last exactly FRAME_CYCLES cycles.
REQ-025 After the last attack frame, the FSM SHALL return to IDLE, or, if an attack is queued, restart ATTACK at frame 0 without passing through IDLE and clear the queue.
REQ-026 attack_grant during ATTACK SHALL set a one-deep queue flag; further grants while the flag is set SHALL be dropped.
REQ-027 damage_in in any state SHALL enter HURT, abort any attack, clear the queue, and hold frame_id=HURT_ID for HURT_CYCLES cycles, then return to IDLE.
REQ-028 damage_in during HURT SHALL restart the hurt counter.
REQ-029 attack_grant during HURT SHALL be ignored and SHALL NOT be queued.
REQ-030 If damage_in and attack_grant arrive in the same cycle, damage_in SHALL win.
REQ-031 mirror SHALL follow action[6] live in IDLE and use the latched facing in ATTACK and HURT.
REQ-032 Counters SHALL be sized by $clog2 of their terminal value and SHALL NOT wrap silently.

Reset
REQ-033 When rst_l=0 at a clk edge, the block SHALL enter IDLE with frame_id=0, mirror=0, busy=0, hit_pulse=0, enemy_damage_animation=0, all counters=0, and the queue clear.
REQ-034 Reset asserted mid-attack or mid-hurt SHALL abort immediately and produce no hit_pulse.

Structure
REQ-035 Package sprite_anim_pkg SHALL hold the action codes (WALKING, CROUCHING, STANDING) and the FSM state encoding.
REQ-036 Frame-base constants SHALL be localparams in the module, because they depend on its parameters.
REQ-037 A single sub-module, anim_tick_counter (period parameter, clear and enable inputs, one-cycle tick output), SHALL be instantiated once for walking and once for attack/hurt timing.

Verification (WALK_FRAMES=3, ATTACK_FRAMES=3, HIT_FRAME=1, FRAME_CYCLES=4, WALK_CYCLES=3, HURT_CYCLES=5)
REQ-038 Walking scenario: action=7'h01 for 12 cycles -> frame_id 2,3,4,2, each held 3 cycles; then action=7'h20 -> frame_id=0 next cycle.
REQ-039 Single attack scenario: attack_grant pulse -> frame_id 5,6,7, each held 4 cycles; hit_pulse high exactly once, on the first cycle of frame 6; enemy_damage_animation high for 4 cycles; busy low after 12 cycles.
REQ-040 Queued attack scenario: second attack_grant during frame 6 -> frame 5 directly follows frame 7; a third grant in the same attack is dropped.
REQ-041 Hurt abort scenario: damage_in during frame 5 -> frame_id=8 for 5 cycles, no hit_pulse; a grant during hurt is ignored.
REQ-042 Simultaneous-event scenario: attack_grant and damage_in in the same IDLE cycle -> HURT; mirror holds its latched value when action[6] toggles during hurt.
REQ-043 Reset scenario: rst_l=0 at cycle 2 of frame 6 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/sprite_anim_pkg.sv
// rtl/sprite_anim_pkg.sv - action codes, decoded movement and FSM state encoding for sprite animation
package sprite_anim_pkg;

    localparam logic [5:0] ACT_CODE_WALKING   = 6'b000001;
    localparam logic [5:0] ACT_CODE_CROUCHING = 6'b000010;
    localparam logic [5:0] ACT_CODE_STANDING  = 6'b100000;

    typedef enum logic [1:0] {
        STANDING  = 2'd0,
        CROUCHING = 2'd1,
        WALKING   = 2'd2
    } move_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ATTACK = 2'd1,
        S_HURT   = 2'd2
    } state_t;

    // Anything that is not an explicit walk or crouch code falls back to standing.
    function automatic move_t decode_action(input logic [5:0] code);
        case (code)
            ACT_CODE_WALKING:   return WALKING;
            ACT_CODE_CROUCHING: return CROUCHING;
            ACT_CODE_STANDING:  return STANDING;
            default:            return STANDING;
        endcase
    endfunction

endpackage

// File: rtl/anim_tick_counter.sv
// rtl/anim_tick_counter.sv - cycle counter that strobes tick_o on the last cycle of each period
module anim_tick_counter #(
    parameter int  PERIOD = 4,
    localparam int W      = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = en_i && !clr_i && (cnt_q == last_i);

    // The terminal value is an explicit compare, so the count never wraps on its own.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == last_i) ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/player_anim_sequencer.sv
// rtl/player_anim_sequencer.sv - selects the player sprite frame from locomotion, attack and hurt events
module player_anim_sequencer
    import sprite_anim_pkg::*;
#(
    parameter int WALK_FRAMES   = 2,
    parameter int ATTACK_FRAMES = 2,
    parameter int HIT_FRAME     = 1,
    parameter int FRAME_CYCLES  = 16_650_000,
    parameter int WALK_CYCLES   = 15_000_000,
    parameter int HURT_CYCLES   = 25_000_000,
    parameter int FID_W         = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [6:0]       action,
    input  logic             attack_grant,
    input  logic             damage_in,
    output logic [FID_W-1:0] frame_id,
    output logic             mirror,
    output logic             busy,
    output logic             hit_pulse,
    output logic             enemy_damage_animation
);

    localparam logic [FID_W-1:0] WALK_BASE = FID_W'(2);
    localparam logic [FID_W-1:0] ATK_BASE  = FID_W'(2 + WALK_FRAMES);
    localparam logic [FID_W-1:0] HURT_ID   = FID_W'(2 + WALK_FRAMES + ATTACK_FRAMES);

    localparam int WI_W       = $clog2(WALK_FRAMES);
    localparam int AI_W       = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
    localparam int WT_W       = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;
    localparam int TMR_PERIOD = (FRAME_CYCLES > HURT_CYCLES) ? FRAME_CYCLES : HURT_CYCLES;
    localparam int TMR_W      = (TMR_PERIOD > 1) ? $clog2(TMR_PERIOD) : 1;

    localparam logic [WI_W-1:0]  WALK_LAST  = WI_W'(WALK_FRAMES - 1);
    localparam logic [AI_W-1:0]  ATK_LAST   = AI_W'(ATTACK_FRAMES - 1);
    localparam logic [AI_W-1:0]  HIT_IDX    = AI_W'(HIT_FRAME);
    localparam logic [WT_W-1:0]  WALK_TERM  = WT_W'(WALK_CYCLES - 1);
    localparam logic [TMR_W-1:0] FRAME_TERM = TMR_W'(FRAME_CYCLES - 1);
    localparam logic [TMR_W-1:0] HURT_TERM  = TMR_W'(HURT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [AI_W-1:0]  atk_q, atk_d;
    logic [WI_W-1:0]  walk_idx_q, walk_idx_d;
    logic             walk_on_q, walk_on_d;
    logic             queued_q, queued_d;
    logic             facing_q, facing_d;
    logic [FID_W-1:0] frame_q, frame_d;
    logic             mirror_q, mirror_d;
    logic             busy_q, busy_d;
    logic             hit_q, hit_d;
    logic             dmg_q, dmg_d;

    move_t            move;
    logic             idle_walk, walk_en, walk_clr, walk_tick;
    logic             tmr_clr, tmr_en, tmr_tick;
    logic [TMR_W-1:0] tmr_last;
    logic             frame_change;

    assign move      = decode_action(action[5:0]);
    assign idle_walk = (state_q == S_IDLE) && (move == WALKING);
    // walk_on_q gates the first displayed walk cycle so every walk frame is held a full period.
    assign walk_en   = idle_walk && walk_on_q;
    assign walk_clr  = !idle_walk;
    assign tmr_clr   = (state_q == S_IDLE) || damage_in;
    assign tmr_en    = (state_q != S_IDLE);
    assign tmr_last  = (state_q == S_HURT) ? HURT_TERM : FRAME_TERM;

    anim_tick_counter #(.PERIOD(WALK_CYCLES)) u_walk_tick (
        .clk    (clk),
        .rst_l  (rst_l),
        .clr_i  (walk_clr),
        .en_i   (walk_en),
        .last_i (WALK_TERM),
        .tick_o (walk_tick)
    );

    anim_tick_counter #(.PERIOD(TMR_PERIOD)) u_phase_tick (
        .clk    (clk),
        .rst_l  (rst_l),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .last_i (tmr_last),
        .tick_o (tmr_tick)
    );

    always_comb begin
        state_d    = state_q;
        atk_d      = atk_q;
        queued_d   = queued_q;
        facing_d   = facing_q;
        walk_idx_d = walk_idx_q;

        if (!idle_walk) begin
            walk_idx_d = '0;
        end else if (walk_tick) begin
            walk_idx_d = (walk_idx_q == WALK_LAST) ? '0 : walk_idx_q + WI_W'(1);
        end

        // Damage outranks everything, including a grant in the same cycle.
        if (damage_in) begin
            state_d  = S_HURT;
            atk_d    = '0;
            queued_d = 1'b0;
            if (state_q == S_IDLE) begin
                facing_d = action[6];
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (attack_grant) begin
                        state_d  = S_ATTACK;
                        atk_d    = '0;
                        queued_d = 1'b0;
                        facing_d = action[6];
                    end
                end
                S_ATTACK: begin
                    if (attack_grant && !queued_q) begin
                        queued_d = 1'b1;
                    end
                    if (tmr_tick) begin
                        if (atk_q == ATK_LAST) begin
                            atk_d    = '0;
                            queued_d = 1'b0;
                            if (!(queued_q || attack_grant)) begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            atk_d = atk_q + AI_W'(1);
                        end
                    end
                end
                S_HURT: begin
                    if (tmr_tick) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        frame_change = (state_d == S_ATTACK) && ((state_q != S_ATTACK) || tmr_tick);
        hit_d        = frame_change && (atk_d == HIT_IDX);
        dmg_d        = (state_d == S_ATTACK) && (atk_d == HIT_IDX);
        busy_d       = (state_d != S_IDLE);
        walk_on_d    = (state_d == S_IDLE) && (move == WALKING);
        mirror_d     = (state_d == S_IDLE) ? action[6] : facing_d;

        frame_d = '0;
        case (state_d)
            S_IDLE: begin
                case (move)
                    CROUCHING: frame_d = FID_W'(1);
                    WALKING:   frame_d = WALK_BASE + FID_W'(walk_idx_d);
                    default:   frame_d = '0;
                endcase
            end
            S_ATTACK: frame_d = ATK_BASE + FID_W'(atk_d);
            S_HURT:   frame_d = HURT_ID;
            default:  frame_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            atk_q      <= '0;
            walk_idx_q <= '0;
            walk_on_q  <= 1'b0;
            queued_q   <= 1'b0;
            facing_q   <= 1'b0;
            frame_q    <= '0;
            mirror_q   <= 1'b0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
            dmg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            atk_q      <= atk_d;
            walk_idx_q <= walk_idx_d;
            walk_on_q  <= walk_on_d;
            queued_q   <= queued_d;
            facing_q   <= facing_d;
            frame_q    <= frame_d;
            mirror_q   <= mirror_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
            dmg_q      <= dmg_d;
        end
    end

    assign frame_id               = frame_q;
    assign mirror                 = mirror_q;
    assign busy                   = busy_q;
    assign hit_pulse              = hit_q;
    assign enemy_damage_animation = dmg_q;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// tb/tb_player_anim_sequencer.sv - scoreboard bench for player_anim_sequencer with small timing parameters
module tb_player_anim_sequencer;

    typedef struct packed {
        logic [3:0] frame;
        logic       mirror;
        logic       busy;
        logic       hit;
        logic       dmg;
    } obs_t;

    logic       clk;
    logic       rst_l;
    logic [6:0] action;
    logic       attack_grant;
    logic       damage_in;
    logic [3:0] frame_id;
    logic       mirror;
    logic       busy;
    logic       hit_pulse;
    logic       enemy_damage_animation;

    obs_t obs;
    obs_t exp_v;
    obs_t exp_q[$];
    int   n_assert;
    int   n_fail;

    player_anim_sequencer #(
        .WALK_FRAMES   (3),
        .ATTACK_FRAMES (3),
        .HIT_FRAME     (1),
        .FRAME_CYCLES  (4),
        .WALK_CYCLES   (3),
        .HURT_CYCLES   (5),
        .FID_W         (4)
    ) dut (
        .clk                    (clk),
        .rst_l                  (rst_l),
        .action                 (action),
        .attack_grant           (attack_grant),
        .damage_in              (damage_in),
        .frame_id               (frame_id),
        .mirror                 (mirror),
        .busy                   (busy),
        .hit_pulse              (hit_pulse),
        .enemy_damage_animation (enemy_damage_animation)
    );

    assign obs = '{frame: frame_id, mirror: mirror, busy: busy, hit: hit_pulse, dmg: enemy_damage_animation};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int f, input bit m, input bit b, input bit h, input bit d);
        obs_t o;
        o.frame  = 4'(f);
        o.mirror = m;
        o.busy   = b;
        o.hit    = h;
        o.dmg    = d;
        return o;
    endfunction

    task automatic test_reset();
        rst_l = 1'b0; action = 7'h00; attack_grant = 1'b0; damage_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset c%0d: got %h expected %h", c, obs, exp_v);
            end
        end
        rst_l = 1'b1;
    endtask

    task automatic test_walk();
        for (int c = 0; c < 16; c++) begin
            action = (c < 12) ? 7'h01 : (c == 12) ? 7'h20 : (c == 13) ? 7'h42 : (c == 14) ? 7'h40 : 7'h03;
            exp_q.push_back(mk((c < 12) ? 2 + (c / 3) % 3 : (c == 13) ? 1 : 0,
                               (c == 13) || (c == 14), 0, 0, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL walk c%0d: got frame=%0d m=%b b=%b h=%b d=%b expected frame=%0d m=%b b=%b h=%b d=%b",
                         c, obs.frame, obs.mirror, obs.busy, obs.hit, obs.dmg,
                         exp_v.frame, exp_v.mirror, exp_v.busy, exp_v.hit, exp_v.dmg);
            end
        end
        action = 7'h00;
    endtask

    task automatic test_single_attack();
        for (int c = 0; c < 14; c++) begin
            action       = (c == 0) ? 7'h40 : 7'h00;
            attack_grant = (c == 0);
            exp_q.push_back(mk((c < 4) ? 5 : (c < 8) ? 6 : (c < 12) ? 7 : 0,
                               c < 12, c < 12, c == 4, (c >= 4) && (c < 8)));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_attack c%0d: got frame=%0d m=%b b=%b h=%b d=%b expected frame=%0d m=%b b=%b h=%b d=%b",
                         c, obs.frame, obs.mirror, obs.busy, obs.hit, obs.dmg,
                         exp_v.frame, exp_v.mirror, exp_v.busy, exp_v.hit, exp_v.dmg);
            end
        end
        attack_grant = 1'b0;
    endtask

    task automatic test_back_to_back();
        int f;
        for (int c = 0; c < 26; c++) begin
            action       = 7'h00;
            attack_grant = (c == 0) || (c == 5) || (c == 9);
            f = (c < 24) ? 5 + ((c % 12) / 4) : 0;
            exp_q.push_back(mk(f, 0, c < 24, (c == 4) || (c == 16), (c < 24) && (f == 6)));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got frame=%0d m=%b b=%b h=%b d=%b expected frame=%0d m=%b b=%b h=%b d=%b",
                         c, obs.frame, obs.mirror, obs.busy, obs.hit, obs.dmg,
                         exp_v.frame, exp_v.mirror, exp_v.busy, exp_v.hit, exp_v.dmg);
            end
        end
        attack_grant = 1'b0;
    endtask

    task automatic test_hurt_abort();
        for (int c = 0; c < 9; c++) begin
            action       = 7'h00;
            attack_grant = (c == 0) || (c == 4);
            damage_in    = (c == 2);
            exp_q.push_back(mk((c < 2) ? 5 : (c < 7) ? 8 : 0, 0, c < 7, 0, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hurt_abort c%0d: got frame=%0d m=%b b=%b h=%b d=%b expected frame=%0d m=%b b=%b h=%b d=%b",
                         c, obs.frame, obs.mirror, obs.busy, obs.hit, obs.dmg,
                         exp_v.frame, exp_v.mirror, exp_v.busy, exp_v.hit, exp_v.dmg);
            end
        end
        attack_grant = 1'b0;
        damage_in    = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 10; c++) begin
            action       = ((c == 0) || (c == 2) || (c == 5) || (c == 9)) ? 7'h40 : 7'h00;
            attack_grant = (c == 0);
            damage_in    = (c == 0) || (c == 3);
            exp_q.push_back(mk((c < 8) ? 8 : 0, (c < 8) || (c == 9), c < 8, 0, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL simultaneous c%0d: got frame=%0d m=%b b=%b h=%b d=%b expected frame=%0d m=%b b=%b h=%b d=%b",
                         c, obs.frame, obs.mirror, obs.busy, obs.hit, obs.dmg,
                         exp_v.frame, exp_v.mirror, exp_v.busy, exp_v.hit, exp_v.dmg);
            end
        end
        action       = 7'h00;
        attack_grant = 1'b0;
        damage_in    = 1'b0;
    endtask

    task automatic test_reset_mid_attack();
        for (int c = 0; c < 8; c++) begin
            action       = 7'h00;
            attack_grant = (c == 0);
            rst_l        = (c != 5);
            exp_q.push_back((c < 4) ? mk(5, 0, 1, 0, 0) : (c == 4) ? mk(6, 0, 1, 1, 1) : mk(0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_attack c%0d: got frame=%0d m=%b b=%b h=%b d=%b expected frame=%0d m=%b b=%b h=%b d=%b",
                         c, obs.frame, obs.mirror, obs.busy, obs.hit, obs.dmg,
                         exp_v.frame, exp_v.mirror, exp_v.busy, exp_v.hit, exp_v.dmg);
            end
        end
        rst_l        = 1'b1;
        attack_grant = 1'b0;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst_l        = 1'b0;
        action       = 7'h00;
        attack_grant = 1'b0;
        damage_in    = 1'b0;
        test_reset();
        test_walk();
        test_single_attack();
        test_back_to_back();
        test_hurt_abort();
        test_simultaneous();
        test_reset_mid_attack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
